// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller.
//   fetch_state_e     - fetch FSM state (IDLE / BUSY / SQUASH)
//   RESET_PC_DEFAULT  - default first fetch address after reset
//   NOP               - instruction word loaded when the IF/ID entry is flushed
//   INSTR_W           - instruction word width
package fetch_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,   // no request outstanding
        ST_BUSY,   // request outstanding, returned data is kept
        ST_SQUASH  // request outstanding, returned data is discarded
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction memory request/response bus.
//   imem_req   - request valid, held with imem_addr until imem_ready
//   imem_addr  - word-aligned request address
//   imem_ready - memory accepts the request and returns data this cycle
//   imem_rdata - instruction word, valid in the transfer cycle
// master: fetch controller side; slave: memory side.
interface fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: two-entry instruction/PC buffer (output register + skid entry).
//   clk_i, rst_ni           - clock, asynchronous active-low reset
//   push_i, push_*_i        - returned instruction and its address
//   pop_i                   - head entry consumed this edge
//   clear_i                 - invalidate both entries (has priority)
//   count_o                 - occupied entries (0..2)
//   head_*_o                - output register contents (IF/ID view)
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic [ADDR_W-1:0]  push_pc_i,
    input  logic               pop_i,
    input  logic               clear_i,
    output logic [1:0]         count_o,
    output logic               head_valid_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [ADDR_W-1:0]  head_pc_o,
    output logic [ADDR_W-1:0]  head_pc4_o
);

    logic               h_valid_q, h_valid_d;
    logic [INSTR_W-1:0] h_instr_q, h_instr_d;
    logic [ADDR_W-1:0]  h_pc_q, h_pc_d;
    logic [ADDR_W-1:0]  h_pc4_q, h_pc4_d;
    logic               s_valid_q, s_valid_d;
    logic [INSTR_W-1:0] s_instr_q, s_instr_d;
    logic [ADDR_W-1:0]  s_pc_q, s_pc_d;

    // The skid entry is only ever occupied while the head is, so a pop
    // always refills the head from the skid first, then from the push.
    always_comb begin
        h_valid_d = h_valid_q;
        h_instr_d = h_instr_q;
        h_pc_d    = h_pc_q;
        h_pc4_d   = h_pc4_q;
        s_valid_d = s_valid_q;
        s_instr_d = s_instr_q;
        s_pc_d    = s_pc_q;

        if (clear_i) begin
            h_valid_d = 1'b0;
            s_valid_d = 1'b0;
            h_instr_d = NOP;
        end else if (pop_i && h_valid_q) begin
            if (s_valid_q) begin
                h_instr_d = s_instr_q;
                h_pc_d    = s_pc_q;
                h_pc4_d   = s_pc_q + ADDR_W'(4);
                s_valid_d = push_i;
                if (push_i) begin
                    s_instr_d = push_instr_i;
                    s_pc_d    = push_pc_i;
                end
            end else if (push_i) begin
                h_instr_d = push_instr_i;
                h_pc_d    = push_pc_i;
                h_pc4_d   = push_pc_i + ADDR_W'(4);
            end else begin
                h_valid_d = 1'b0;
            end
        end else if (push_i) begin
            if (!h_valid_q) begin
                h_valid_d = 1'b1;
                h_instr_d = push_instr_i;
                h_pc_d    = push_pc_i;
                h_pc4_d   = push_pc_i + ADDR_W'(4);
            end else begin
                s_valid_d = 1'b1;
                s_instr_d = push_instr_i;
                s_pc_d    = push_pc_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_valid_q <= 1'b0;
            h_instr_q <= '0;
            h_pc_q    <= '0;
            h_pc4_q   <= '0;
            s_valid_q <= 1'b0;
            s_instr_q <= '0;
            s_pc_q    <= '0;
        end else begin
            h_valid_q <= h_valid_d;
            h_instr_q <= h_instr_d;
            h_pc_q    <= h_pc_d;
            h_pc4_q   <= h_pc4_d;
            s_valid_q <= s_valid_d;
            s_instr_q <= s_instr_d;
            s_pc_q    <= s_pc_d;
        end
    end

    assign count_o      = {1'b0, h_valid_q} + {1'b0, s_valid_q};
    assign head_valid_o = h_valid_q;
    assign head_instr_o = h_instr_q;
    assign head_pc_o    = h_pc_q;
    assign head_pc4_o   = h_pc4_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with branch redirect/squash.
//   clk, rst        - clock, asynchronous active-low reset
//   stall           - decode not accepting; IF outputs held
//   PCSrc, PCBranch - taken branch/jump pulse and its target
//   imem            - instruction memory bus (master side)
//   instr_valid, instr, pc_addr, pcplus4_addr - IF/ID entry
//   flush_ifid      - one-cycle pulse after a redirect
//   misalign        - one-cycle pulse when the redirect target was unaligned
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  PCBranch,
    fetch_ctrl_if.master       imem,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_addr,
    output logic [ADDR_W-1:0]  pcplus4_addr,
    output logic               flush_ifid,
    output logic               misalign
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;   // outstanding request address
    logic [ADDR_W-1:0] pc_q, pc_d;       // next address to issue
    logic              flush_q, flush_d;
    logic              mis_q, mis_d;

    logic              transfer;
    logic              pop;
    logic              push;
    logic              clear;
    logic [1:0]        buf_count;
    logic [2:0]        occ_after_pop;
    logic              room_idle;
    logic              room_busy;
    logic [ADDR_W-1:0] target;

    assign imem.imem_req  = (state_q != ST_IDLE);
    assign imem.imem_addr = addr_q;
    assign transfer       = imem.imem_req && imem.imem_ready;
    assign pop            = instr_valid && !stall;
    assign target         = {PCBranch[ADDR_W-1:2], 2'b00};

    // Issue only while entries + outstanding requests stay within the two
    // storage slots, judged on the occupancy after this edge so that a
    // zero-wait memory with a consuming decoder sustains one fetch per cycle.
    assign occ_after_pop = {1'b0, buf_count} - {2'b00, pop};
    assign room_idle     = (occ_after_pop < 3'd2);
    assign room_busy     = (occ_after_pop < 3'd1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
        mis_d   = 1'b0;
        push    = 1'b0;
        clear   = 1'b0;

        if (PCSrc) begin
            clear   = 1'b1;
            flush_d = 1'b1;
            mis_d   = |PCBranch[1:0];
            if (state_q == ST_IDLE || transfer) begin
                state_d = ST_BUSY;
                addr_d  = target;
                pc_d    = target + ADDR_W'(4);
            end else begin
                // Request cannot be withdrawn; park the target until it lands.
                state_d = ST_SQUASH;
                pc_d    = target;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (room_idle) begin
                        state_d = ST_BUSY;
                        addr_d  = pc_q;
                        pc_d    = pc_q + ADDR_W'(4);
                    end
                end
                ST_BUSY: begin
                    if (transfer) begin
                        push = 1'b1;
                        if (room_busy) begin
                            addr_d = pc_q;
                            pc_d   = pc_q + ADDR_W'(4);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_SQUASH: begin
                    if (transfer) begin
                        state_d = ST_BUSY;
                        addr_d  = pc_q;
                        pc_d    = pc_q + ADDR_W'(4);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

    fetch_buf #(
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk_i        (clk),
        .rst_ni       (rst),
        .push_i       (push),
        .push_instr_i (imem.imem_rdata),
        .push_pc_i    (addr_q),
        .pop_i        (pop),
        .clear_i      (clear),
        .count_o      (buf_count),
        .head_valid_o (instr_valid),
        .head_instr_o (instr),
        .head_pc_o    (pc_addr),
        .head_pc4_o   (pcplus4_addr)
    );

    assign flush_ifid = flush_q;
    assign misalign   = mis_q;

endmodule
